branch_unit: RTL

Parametrised branch/PC-sequencing unit for the control-flow path of the 19-bit core. It holds the program counter and resolves conditional branches (BEQ/BNE/BLT/BGE), unconditional jumps, and CALL/RET through an internal return-address stack (RAS). Instruction issue feeds it one decoded control-flow op per cycle, and its registered `pc` drives instruction fetch.

---
 rtl/branch_pkg.sv | 19 +
 rtl/branch_ras.sv | 57 +++++
 rtl/branch_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// branch_pkg: shared constants for the branch/PC-sequencing unit.
//   OP_* : control-flow op codes presented on branch_unit.op
//   OP_W : op code width
//   PERF_W : width of the optional perf counters (BRANCH_PERF_EN)
package branch_pkg;

  localparam int OP_W   = 3;
  localparam int PERF_W = 32;

  localparam logic [OP_W-1:0] OP_BEQ  = 3'b000;
  localparam logic [OP_W-1:0] OP_BNE  = 3'b001;
  localparam logic [OP_W-1:0] OP_BLT  = 3'b010;
  localparam logic [OP_W-1:0] OP_BGE  = 3'b011;
  localparam logic [OP_W-1:0] OP_JMP  = 3'b100;
  localparam logic [OP_W-1:0] OP_CALL = 3'b101;
  localparam logic [OP_W-1:0] OP_RET  = 3'b110;
  localparam logic [OP_W-1:0] OP_NOP  = 3'b111;

endpackage

// File: rtl/branch_ras.sv
// branch_ras: circular return-address stack.
//   clk, rst   : clock, synchronous active-high reset (empties the stack)
//   push       : write push_data on top; when full the oldest entry is overwritten
//   pop        : drop top entry; ignored when empty
//   push_data  : return address to store
//   top        : combinational top-of-stack (most recent push)
//   full/empty : occupancy flags (post-edge)
//   overflow   : push while full (combinational, same cycle as push)
//   underflow  : pop while empty (combinational, same cycle as pop)
module branch_ras #(
  parameter int XLEN      = 19,
  parameter int RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            full,
  output logic            empty,
  output logic            overflow,
  output logic            underflow
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;    // next free slot; wraps so a full push lands on the oldest entry
  logic [CNT_W-1:0] count;

  assign full      = (count == CNT_W'(RAS_DEPTH));
  assign empty     = (count == '0);
  assign overflow  = push && full;
  assign underflow = pop && !push && empty;
  assign top       = mem[ptr - PTR_W'(1)];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

  // Contents need no reset: count==0 makes them unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/branch_unit.sv
// branch_unit: program counter and control-flow resolution for the 19-bit core.
// Optional feature macro: BRANCH_PERF_EN adds perf_taken / perf_not_taken.
//   clk, rst      : clock, synchronous active-high reset
//   br_valid      : op and operands valid this cycle
//   stall         : hold all state (overrides br_valid)
//   op            : branch_pkg op code
//   rs1, rs2      : compare operands (signed for BLT/BGE)
//   target        : absolute branch/jump/call address
//   pc            : registered program counter
//   taken         : last accepted op redirected the PC (one cycle)
//   ras_full/empty: return-address stack occupancy
//   ras_err       : one-cycle pulse on RAS overflow or underflow
//   perf_taken/perf_not_taken : saturating outcome counters (BRANCH_PERF_EN only)
module branch_unit
  import branch_pkg::*;
#(
  parameter int              XLEN      = 19,
  parameter int              RAS_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  input  logic              stall,
  input  logic [OP_W-1:0]   op,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  input  logic [XLEN-1:0]   target,
  output logic [XLEN-1:0]   pc,
  output logic              taken,
  output logic              ras_full,
  output logic              ras_empty,
`ifdef BRANCH_PERF_EN
  output logic [PERF_W-1:0] perf_taken,
  output logic [PERF_W-1:0] perf_not_taken,
`endif
  output logic              ras_err
);

  logic            accept;
  logic            is_eq;
  logic            is_lt;
  logic            taken_nxt;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] ras_top;
  logic            ras_push;
  logic            ras_pop;
  logic            ras_ovf;
  logic            ras_unf;

  assign accept   = br_valid && !stall && !rst;
  assign pc_inc   = pc + XLEN'(1);
  assign is_eq    = (rs1 == rs2);
  assign is_lt    = ($signed(rs1) < $signed(rs2));
  assign ras_push = accept && (op == OP_CALL);
  assign ras_pop  = accept && (op == OP_RET);

  branch_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty),
    .overflow  (ras_ovf),
    .underflow (ras_unf)
  );

  always_comb begin
    taken_nxt = 1'b0;
    case (op)
      OP_BEQ:  taken_nxt = is_eq;
      OP_BNE:  taken_nxt = !is_eq;
      OP_BLT:  taken_nxt = is_lt;
      OP_BGE:  taken_nxt = !is_lt;
      OP_JMP:  taken_nxt = 1'b1;
      OP_CALL: taken_nxt = 1'b1;
      OP_RET:  taken_nxt = !ras_empty;  // empty RET falls through to pc+1
      default: taken_nxt = 1'b0;
    endcase
  end

  assign pc_nxt = !taken_nxt      ? pc_inc  :
                  (op == OP_RET)  ? ras_top : target;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      taken   <= 1'b0;
      ras_err <= 1'b0;
    end else if (stall) begin
      taken   <= 1'b0;
      ras_err <= 1'b0;
    end else if (br_valid) begin
      pc      <= pc_nxt;
      taken   <= taken_nxt;
      ras_err <= ras_ovf || ras_unf;
    end else begin
      pc      <= pc_inc;
      taken   <= 1'b0;
      ras_err <= 1'b0;
    end
  end

`ifdef BRANCH_PERF_EN
  // Conditional branches, JMP and CALL are counted; RET and NOP are not.
  logic perf_cnt_op;
  assign perf_cnt_op = (op <= OP_JMP) || (op == OP_CALL);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_taken     <= '0;
      perf_not_taken <= '0;
    end else if (accept && perf_cnt_op) begin
      if (taken_nxt) begin
        if (perf_taken != '1) perf_taken <= perf_taken + PERF_W'(1);
      end else begin
        if (perf_not_taken != '1) perf_not_taken <= perf_not_taken + PERF_W'(1);
      end
    end
  end
`endif

endmodule
